ready_bit_clear_controller: RTL and testbench

- Sequences bulk initialisation of the scheduler's ready-bit table after reset and on pipeline flush.
- Owns the table's clear write ports. Walks all physical-register entries CLEAR_PORT_NUM per cycle and asserts busy so rename/dispatch and wakeup writers are held off.
- Pulses done when the table is fully ready. It sits beside the ready-bit table and drives the write-port muxes in front of it.

---
 rtl/ready_bit_clear_controller_if.sv | 58 +++++
 rtl/ready_bit_clear_controller.sv | 147 ++++++++++++++
 tb/tb_ready_bit_clear_controller.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ready_bit_clear_controller_if.sv
// ---------------------------------------------------------------------------
// ready_bit_clear_controller_if
//
// Purpose: groups the clear-port bus between the ready-bit clear controller
// and the write-port muxes in front of the scheduler's ready-bit table.
//
// Signals:
//   clearReq        request a full re-clear (flush), level or pulse
//   clrWE           per-port write enable
//   clrWA           per-port write address
//   clrWV           per-port write value (always the clear value)
//   busy            clear in progress; table ports belong to the controller
//   done            one-cycle pulse after the final clear write
//   clearCycleCount 16-bit busy-cycle counter (only with
//                   RBT_CLEAR_CYCLE_COUNT_EN defined)
//
// Modports:
//   master  controller side (drives the write ports, busy, done)
//   slave   table / pipeline side (drives clearReq)
// ---------------------------------------------------------------------------
interface ready_bit_clear_controller_if #(
  parameter int unsigned CLEAR_PORT_NUM    = 2,
  parameter int unsigned REG_NUM_BIT_WIDTH = 6
);

  logic                                               clearReq;
  logic [CLEAR_PORT_NUM-1:0]                          clrWE;
  logic [CLEAR_PORT_NUM-1:0][REG_NUM_BIT_WIDTH-1:0]   clrWA;
  logic [CLEAR_PORT_NUM-1:0]                          clrWV;
  logic                                               busy;
  logic                                               done;
`ifdef RBT_CLEAR_CYCLE_COUNT_EN
  logic [15:0]                                        clearCycleCount;
`endif

`ifdef RBT_CLEAR_CYCLE_COUNT_EN
  modport master (
    input  clearReq,
    output clrWE, clrWA, clrWV, busy, done, clearCycleCount
  );

  modport slave (
    output clearReq,
    input  clrWE, clrWA, clrWV, busy, done, clearCycleCount
  );
`else
  modport master (
    input  clearReq,
    output clrWE, clrWA, clrWV, busy, done
  );

  modport slave (
    output clearReq,
    input  clrWE, clrWA, clrWV, busy, done
  );
`endif

endinterface : ready_bit_clear_controller_if

// File: rtl/ready_bit_clear_controller.sv
// ---------------------------------------------------------------------------
// ready_bit_clear_controller
//
// Purpose: sequences bulk initialisation of the scheduler's ready-bit table
// after reset and on pipeline flush. Walks every physical-register entry,
// CLEAR_PORT_NUM entries per cycle, writing CLEAR_VALUE through the table's
// clear write ports. busy holds off rename/dispatch and wakeup writers while
// the walk runs; done pulses for one cycle once the table is fully ready.
//
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   ready_bit_clear_controller_if.master
//         (clearReq in; clrWE/clrWA/clrWV/busy/done out)
//
// Optional feature (macro RBT_CLEAR_CYCLE_COUNT_EN):
//   bus.clearCycleCount, a 16-bit saturating count of busy cycles since the
//   last flush-triggered clear began; feeds the flush-penalty perf counters.
// ---------------------------------------------------------------------------
module ready_bit_clear_controller #(
  parameter int unsigned ENTRY_NUM         = 64,
  parameter int unsigned REG_NUM_BIT_WIDTH = 6,
  parameter int unsigned CLEAR_PORT_NUM    = 2,
  parameter bit          CLEAR_VALUE       = 1'b1
) (
  input logic                         clk,
  input logic                         rst,
  ready_bit_clear_controller_if.master bus
);

  localparam int unsigned W = REG_NUM_BIT_WIDTH;

  // Index step and last-group index in index width. When CLEAR_PORT_NUM
  // equals ENTRY_NUM the step truncates to 0 and the last group is index 0,
  // which gives the single-cycle clear without special casing.
  localparam logic [W-1:0] STEP     = W'(CLEAR_PORT_NUM);
  localparam logic [W-1:0] LAST_IDX = W'(ENTRY_NUM - CLEAR_PORT_NUM);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   clear_index_q, clear_index_d;
  logic           done_q, done_d;
`ifdef RBT_CLEAR_CYCLE_COUNT_EN
  logic [15:0]    cycle_count_q, cycle_count_d;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned; that is what keeps always_comb from inferring a latch.
    state_d       = state_q;
    clear_index_d = clear_index_q;
    done_d        = 1'b0;

    unique case (state_q)
      ST_CLEAR: begin
        if (bus.clearReq) begin
          // Restart: this cycle's writes still land, the walk begins again.
          clear_index_d = '0;
        end else begin
          // Last group wraps the index back to 0 through modulo arithmetic.
          clear_index_d = clear_index_q + STEP;
          if (clear_index_q == LAST_IDX) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (bus.clearReq) begin
          state_d       = ST_CLEAR;
          clear_index_d = '0;
        end
      end
      default: begin
        state_d       = ST_CLEAR;
        clear_index_d = '0;
      end
    endcase
  end

`ifdef RBT_CLEAR_CYCLE_COUNT_EN
  // Counts cycles spent clearing; a flush-triggered start zeroes it so the
  // value read afterwards is the penalty of that one flush.
  always_comb begin
    cycle_count_d = cycle_count_q;
    if (state_q == ST_IDLE && bus.clearReq) begin
      cycle_count_d = '0;
    end else if (state_q == ST_CLEAR && cycle_count_q != 16'hFFFF) begin
      cycle_count_d = cycle_count_q + 16'd1;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples its _d value from before the edge, independent of statement
    // order or of other always_ff blocks.
    if (rst) begin
      state_q       <= ST_CLEAR;
      clear_index_q <= '0;
      done_q        <= 1'b0;
`ifdef RBT_CLEAR_CYCLE_COUNT_EN
      cycle_count_q <= '0;
`endif
    end else begin
      state_q       <= state_d;
      clear_index_q <= clear_index_d;
      done_q        <= done_d;
`ifdef RBT_CLEAR_CYCLE_COUNT_EN
      cycle_count_q <= cycle_count_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Writes are gated by rst directly: inputs to the table can be undefined
  // while reset is held, so nothing is written until reset drops.
  logic writing;
  assign writing = !rst && (state_q == ST_CLEAR);

  always_comb begin
    bus.busy = rst || (state_q == ST_CLEAR);
    bus.done = done_q && !rst;
    for (int p = 0; p < int'(CLEAR_PORT_NUM); p++) begin
      bus.clrWE[p] = writing;
      bus.clrWA[p] = writing ? (clear_index_q + W'(p)) : '0;
      bus.clrWV[p] = CLEAR_VALUE;
    end
  end

`ifdef RBT_CLEAR_CYCLE_COUNT_EN
  assign bus.clearCycleCount = cycle_count_q;
`endif

endmodule : ready_bit_clear_controller

// File: tb/tb_ready_bit_clear_controller.sv
// ---------------------------------------------------------------------------
// tb_ready_bit_clear_controller
//
// Self-checking bench for ready_bit_clear_controller. A behavioural model
// tracks how many write groups remain in the current walk and whether a done
// pulse is owed; a compare process checks every output against it on every
// negative clock edge. Directed sequences pin the model with literal values,
// then randomized clearReq/rst traffic exercises restarts and resets.
// A second instance with CLEAR_PORT_NUM == ENTRY_NUM covers the
// single-cycle clear.
// ---------------------------------------------------------------------------
module tb_ready_bit_clear_controller;

  localparam int ENTRY_NUM = 64;
  localparam int W         = 6;
  localparam int CPN       = 2;
  localparam int NG        = ENTRY_NUM / CPN;
  localparam bit CLR_VAL   = 1'b1;

  logic clk;
  logic rst;

  int total = 0;
  int bad   = 0;

  ready_bit_clear_controller_if #(.CLEAR_PORT_NUM(CPN), .REG_NUM_BIT_WIDTH(W)) rb_if ();
  ready_bit_clear_controller_if #(.CLEAR_PORT_NUM(ENTRY_NUM), .REG_NUM_BIT_WIDTH(W)) wide_if ();

  ready_bit_clear_controller #(
    .ENTRY_NUM(ENTRY_NUM), .REG_NUM_BIT_WIDTH(W), .CLEAR_PORT_NUM(CPN), .CLEAR_VALUE(CLR_VAL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(rb_if.master)
  );

  ready_bit_clear_controller #(
    .ENTRY_NUM(ENTRY_NUM), .REG_NUM_BIT_WIDTH(W), .CLEAR_PORT_NUM(ENTRY_NUM), .CLEAR_VALUE(CLR_VAL)
  ) dut_wide (
    .clk(clk),
    .rst(rst),
    .bus(wide_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model: groups still to write in the current walk (0 = idle),
  // whether done is owed this cycle, and the busy-cycle count.
  // -------------------------------------------------------------------------
  int m_remaining = 0;
  bit m_done      = 1'b0;
  int m_cnt       = 0;
  bit m_valid     = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_remaining = NG;
      m_done      = 1'b0;
      m_cnt       = 0;
      m_valid     = 1'b1;
    end else if (m_valid) begin
      if (m_remaining > 0) begin
        if (m_cnt < 65535) m_cnt++;
        if (rb_if.clearReq) begin
          m_remaining = NG;
          m_done      = 1'b0;
        end else begin
          m_remaining--;
          m_done = (m_remaining == 0);
        end
      end else begin
        m_done = 1'b0;
        if (rb_if.clearReq) begin
          m_remaining = NG;
          m_cnt       = 0;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Compare process: every cycle once the model has seen reset.
  // -------------------------------------------------------------------------
  always @(negedge clk) begin : compare
    bit                wr;
    logic [CPN-1:0]    exp_we;
    logic [CPN-1:0]    exp_wv;
    int                base;
    if (m_valid) begin
      wr     = !rst && (m_remaining > 0);
      exp_we = wr ? '1 : '0;
      exp_wv = {CPN{CLR_VAL}};
      base   = (NG - m_remaining) * CPN;
      check("m_busy", 32'(rb_if.busy), 32'(rst || (m_remaining > 0)));
      check("m_done", 32'(rb_if.done), 32'(!rst && m_done));
      check("m_we",   32'(rb_if.clrWE), 32'(exp_we));
      check("m_wv",   32'(rb_if.clrWV), 32'(exp_wv));
      check("m_busy_done_excl", 32'(rb_if.busy & rb_if.done), 32'd0);
      if (!rst) begin
        for (int p = 0; p < CPN; p++) begin
          check("m_wa", 32'(rb_if.clrWA[p]), wr ? 32'((base + p) % ENTRY_NUM) : 32'd0);
        end
      end
`ifdef RBT_CLEAR_CYCLE_COUNT_EN
      check("m_cnt", 32'(rb_if.clearCycleCount), 32'(m_cnt));
`endif
    end
  end

  // One clock cycle: drive inputs just after the rising edge, then return
  // just after the falling edge so the caller can inspect that cycle.
  task automatic cyc(input bit r, input bit q);
    @(posedge clk);
    #2;
    rst            = r;
    rb_if.clearReq = q;
    @(negedge clk);
    #1;
  endtask

  int hold_left;

  initial begin
    rst              = 1'b1;
    rb_if.clearReq   = 1'b0;
    wide_if.clearReq = 1'b0;

    // Reset for three cycles: no writes, busy high.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0);
      check("rst_we",   32'(rb_if.clrWE), 32'd0);
      check("rst_busy", 32'(rb_if.busy), 32'd1);
      check("rst_done", 32'(rb_if.done), 32'd0);
    end

    // First walk after reset: 32 groups, {0,1} .. {62,63}.
    for (int k = 0; k < NG; k++) begin
      cyc(1'b0, 1'b0);
      check("walk_we",  32'(rb_if.clrWE), 32'h3);
      check("walk_wa0", 32'(rb_if.clrWA[0]), 32'(2 * k));
      check("walk_wa1", 32'(rb_if.clrWA[1]), 32'(2 * k + 1));
      if (k == 0) begin
        check("wide_we_lo", wide_if.clrWE[31:0],  32'hFFFF_FFFF);
        check("wide_we_hi", wide_if.clrWE[63:32], 32'hFFFF_FFFF);
        check("wide_wa0",   32'(wide_if.clrWA[0]),  32'd0);
        check("wide_wa63",  32'(wide_if.clrWA[63]), 32'd63);
        check("wide_busy0", 32'(wide_if.busy), 32'd1);
      end
      if (k == 1) begin
        check("wide_done", 32'(wide_if.done), 32'd1);
        check("wide_busy", 32'(wide_if.busy), 32'd0);
      end
`ifdef RBT_CLEAR_CYCLE_COUNT_EN
      if (k == 5) check("wide_cnt", 32'(wide_if.clearCycleCount), 32'd1);
`endif
    end
    cyc(1'b0, 1'b0);
    check("walk_done33", 32'(rb_if.done), 32'd1);
    check("walk_busy33", 32'(rb_if.busy), 32'd0);
`ifdef RBT_CLEAR_CYCLE_COUNT_EN
    check("walk_cnt", 32'(rb_if.clearCycleCount), 32'd32);
`endif
    cyc(1'b0, 1'b0);
    check("walk_done34", 32'(rb_if.done), 32'd0);

    // clearReq pulse in IDLE at cycle T.
    cyc(1'b0, 1'b1);
    check("req_busy_T", 32'(rb_if.busy), 32'd0);
    for (int i = 1; i <= NG; i++) begin
      cyc(1'b0, 1'b0);
      if (i == 1) begin
        check("req_busy_T1", 32'(rb_if.busy), 32'd1);
        check("req_wa_T1",   32'(rb_if.clrWA[0]), 32'd0);
      end
      if (i == NG) check("req_wa_T32", 32'(rb_if.clrWA[1]), 32'd63);
    end
    cyc(1'b0, 1'b0);
    check("req_done_T33", 32'(rb_if.done), 32'd1);

    // Restart while writing {20,21}.
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    check("mid_wa20", 32'(rb_if.clrWA[0]), 32'd20);
    check("mid_we",   32'(rb_if.clrWE), 32'h3);
    for (int i = 1; i <= NG; i++) begin
      cyc(1'b0, 1'b0);
      if (i == 1) check("mid_restart_wa", 32'(rb_if.clrWA[0]), 32'd0);
      if (i == NG) check("mid_no_early_done", 32'(rb_if.done), 32'd0);
    end
    cyc(1'b0, 1'b0);
    check("mid_done", 32'(rb_if.done), 32'd1);

    // Restart on the last-group cycle.
    cyc(1'b0, 1'b1);
    for (int i = 0; i < NG - 1; i++) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    check("last_wa62", 32'(rb_if.clrWA[0]), 32'd62);
    cyc(1'b0, 1'b0);
    check("last_no_done", 32'(rb_if.done), 32'd0);
    check("last_busy",    32'(rb_if.busy), 32'd1);
    check("last_wa0",     32'(rb_if.clrWA[0]), 32'd0);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0);

    // Reset mid-walk at {40,41}.
    cyc(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    check("rstmid_wa40", 32'(rb_if.clrWA[0]), 32'd40);
    cyc(1'b1, 1'b1);
    check("rstmid_we",   32'(rb_if.clrWE), 32'd0);
    check("rstmid_busy", 32'(rb_if.busy), 32'd1);
    cyc(1'b0, 1'b0);
    check("rstmid_wa0",  32'(rb_if.clrWA[0]), 32'd0);
    check("rstmid_we2",  32'(rb_if.clrWE), 32'h3);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0);

    // Randomized traffic: sparse pulses, occasional held requests and resets.
    hold_left = 0;
    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit q;
      if (hold_left == 0 && $urandom_range(0, 299) == 0) hold_left = $urandom_range(2, 8);
      r = ($urandom_range(0, 199) == 0);
      q = (hold_left > 0) || ($urandom_range(0, 29) == 0);
      if (hold_left > 0) hold_left--;
      cyc(r, q);
    end
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0);
    check("end_idle_busy", 32'(rb_if.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ready_bit_clear_controller
